tl_mem_responder: RTL and testbench

TL-UL device-side responder that terminates one TileLink port and drives a single-port ROM/RAM macro. Sits between the crossbar device port and the on-chip 128 KiB memory. Accepts Get/PutFullData/PutPartialData, checks legality, issues at most one memory access per cycle and returns AccessAck/AccessAckData in order. A response queue absorbs D-channel backpressure.

---
 rtl/tl_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_tl_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_mem_responder.sv
// TL-UL device responder driving a single-port ROM/RAM macro, with an in-order response queue.
// Define TL_MEM_RO_EN for ROM mode: writes are rejected and mem_we_o is tied low.
module tl_mem_responder #(
    parameter int AW       = 17,
    parameter int DW       = 32,
    parameter int RspDepth = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tl_a_valid_i,
    input  logic [2:0]        tl_a_opcode_i,
    input  logic [2:0]        tl_a_param_i,
    input  logic [1:0]        tl_a_size_i,
    input  logic [7:0]        tl_a_source_i,
    input  logic [31:0]       tl_a_address_i,
    input  logic [DW/8-1:0]   tl_a_mask_i,
    input  logic [DW-1:0]     tl_a_data_i,
    output logic              tl_a_ready_o,
    output logic              tl_d_valid_o,
    output logic [2:0]        tl_d_opcode_o,
    output logic [1:0]        tl_d_size_o,
    output logic [7:0]        tl_d_source_o,
    output logic [DW-1:0]     tl_d_data_o,
    output logic              tl_d_error_o,
    input  logic              tl_d_ready_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AW-3:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    output logic [DW/8-1:0]   mem_be_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam int MW   = DW / 8;
    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;

    // Handshakes: A fires on tl_a_valid_i & tl_a_ready_o, D fires on tl_d_valid_o & tl_d_ready_i;
    // a valid, once raised, holds its payload stable until the matching ready is seen.

    logic [2:0]      op_q   [RspDepth];
    logic [2:0]      op_d   [RspDepth];
    logic [1:0]      size_q [RspDepth];
    logic [1:0]      size_d [RspDepth];
    logic [7:0]      src_q  [RspDepth];
    logic [7:0]      src_d  [RspDepth];
    logic            err_q  [RspDepth];
    logic            err_d  [RspDepth];
    logic [DW-1:0]   data_q [RspDepth];
    logic [DW-1:0]   data_d [RspDepth];
    logic            pend_q [RspDepth];
    logic            pend_d [RspDepth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            a_fire;
    logic            d_fire;
    logic            legal;
    logic            op_ok;
    logic            aligned;
    logic [MW-1:0]   lane_mask;
    logic            is_get;
    logic            unused_param;

    assign unused_param = ^tl_a_param_i;

    assign tl_a_ready_o = (count_q < CntW'(RspDepth));
    assign tl_d_valid_o = (count_q != '0);
    assign a_fire       = tl_a_valid_i & tl_a_ready_o;
    assign d_fire       = tl_d_valid_o & tl_d_ready_i;
    assign is_get       = (tl_a_opcode_i == OpGet);

    // Legality: the byte lanes a request may touch follow from size and the low address bits.
    always_comb begin
        lane_mask = '0;
        aligned   = 1'b0;
        case (tl_a_size_i)
            2'd0: begin
                lane_mask = MW'(1) << tl_a_address_i[1:0];
                aligned   = 1'b1;
            end
            2'd1: begin
                lane_mask = MW'(3) << {tl_a_address_i[1], 1'b0};
                aligned   = ~tl_a_address_i[0];
            end
            2'd2: begin
                lane_mask = '1;
                aligned   = (tl_a_address_i[1:0] == 2'b00);
            end
            default: begin
                lane_mask = '0;
                aligned   = 1'b0;
            end
        endcase
`ifdef TL_MEM_RO_EN
        op_ok = is_get;
`else
        op_ok = is_get || (tl_a_opcode_i == OpPutFull) || (tl_a_opcode_i == OpPutPartial);
`endif
        legal = op_ok && aligned
             && (tl_a_mask_i != '0)
             && ((tl_a_mask_i & ~lane_mask) == '0)
             && ((tl_a_opcode_i != OpPutFull) || (tl_a_mask_i == lane_mask))
             && (tl_a_address_i[31:AW] == '0);
    end

    assign mem_req_o   = a_fire & legal;
`ifdef TL_MEM_RO_EN
    assign mem_we_o    = 1'b0;
`else
    assign mem_we_o    = mem_req_o & ~is_get;
`endif
    assign mem_addr_o  = mem_req_o ? tl_a_address_i[AW-1:2] : '0;
    assign mem_wdata_o = mem_req_o ? tl_a_data_i : '0;
    assign mem_be_o    = mem_req_o ? tl_a_mask_i : '0;

    // Queue update. A pending read lands one cycle after its push; depth >= 2 guarantees the
    // slot being pushed this cycle is never the one still waiting for read data.
    always_comb begin
        op_d     = op_q;
        size_d   = size_q;
        src_d    = src_q;
        err_d    = err_q;
        data_d   = data_q;
        pend_d   = pend_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        for (int i = 0; i < RspDepth; i++) begin
            if (pend_q[i]) begin
                data_d[i] = mem_rdata_i;
                pend_d[i] = 1'b0;
            end
        end

        if (a_fire) begin
            op_d[wr_ptr_q]   = is_get ? 3'd1 : 3'd0;
            size_d[wr_ptr_q] = tl_a_size_i;
            src_d[wr_ptr_q]  = tl_a_source_i;
            err_d[wr_ptr_q]  = ~legal;
            data_d[wr_ptr_q] = '0;
            pend_d[wr_ptr_q] = legal & is_get;
            wr_ptr_d = (wr_ptr_q == PtrW'(RspDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end

        if (d_fire) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(RspDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end

        case ({a_fire, d_fire})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RspDepth; i++) begin
                op_q[i]   <= '0;
                size_q[i] <= '0;
                src_q[i]  <= '0;
                err_q[i]  <= 1'b0;
                data_q[i] <= '0;
                pend_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            op_q     <= op_d;
            size_q   <= size_d;
            src_q    <= src_d;
            err_q    <= err_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // D payload is forced to zero while the queue is empty.
    assign tl_d_opcode_o = tl_d_valid_o ? op_q[rd_ptr_q]   : '0;
    assign tl_d_size_o   = tl_d_valid_o ? size_q[rd_ptr_q] : '0;
    assign tl_d_source_o = tl_d_valid_o ? src_q[rd_ptr_q]  : '0;
    assign tl_d_error_o  = tl_d_valid_o ? err_q[rd_ptr_q]  : 1'b0;
    assign tl_d_data_o   = !tl_d_valid_o    ? '0 :
                           pend_q[rd_ptr_q] ? mem_rdata_i : data_q[rd_ptr_q];

endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed bench for tl_mem_responder: byte-lane memory model, hand-computed responses.
// Compile with TL_MEM_RO_EN defined to exercise the ROM build.
module tb_tl_mem_responder;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        tl_a_valid_i = 1'b0;
    logic [2:0]  tl_a_opcode_i = '0;
    logic [2:0]  tl_a_param_i = '0;
    logic [1:0]  tl_a_size_i = '0;
    logic [7:0]  tl_a_source_i = '0;
    logic [31:0] tl_a_address_i = '0;
    logic [3:0]  tl_a_mask_i = '0;
    logic [31:0] tl_a_data_i = '0;
    logic        tl_a_ready_o;
    logic        tl_d_valid_o;
    logic [2:0]  tl_d_opcode_o;
    logic [1:0]  tl_d_size_o;
    logic [7:0]  tl_d_source_o;
    logic [31:0] tl_d_data_o;
    logic        tl_d_error_o;
    logic        tl_d_ready_i = 1'b1;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [14:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];

    tl_mem_responder #(.AW(17), .DW(32), .RspDepth(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .tl_a_valid_i   (tl_a_valid_i),
        .tl_a_opcode_i  (tl_a_opcode_i),
        .tl_a_param_i   (tl_a_param_i),
        .tl_a_size_i    (tl_a_size_i),
        .tl_a_source_i  (tl_a_source_i),
        .tl_a_address_i (tl_a_address_i),
        .tl_a_mask_i    (tl_a_mask_i),
        .tl_a_data_i    (tl_a_data_i),
        .tl_a_ready_o   (tl_a_ready_o),
        .tl_d_valid_o   (tl_d_valid_o),
        .tl_d_opcode_o  (tl_d_opcode_o),
        .tl_d_size_o    (tl_d_size_o),
        .tl_d_source_o  (tl_d_source_o),
        .tl_d_data_o    (tl_d_data_o),
        .tl_d_error_o   (tl_d_error_o),
        .tl_d_ready_i   (tl_d_ready_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Single-port memory: byte-enabled writes, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) mem[mem_addr_o[9:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= mem[mem_addr_o[9:0]];
            end
        end
    end

    // D tuple: {valid, opcode, size, source, error, data}
    function automatic logic [46:0] d_tuple();
        return {tl_d_valid_o, tl_d_opcode_o, tl_d_size_o, tl_d_source_o, tl_d_error_o, tl_d_data_o};
    endfunction

    function automatic logic [52:0] m_tuple();
        return {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
    endfunction

    task automatic drive_a(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                           input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        tl_a_valid_i   = 1'b1;
        tl_a_opcode_i  = op;
        tl_a_size_i    = sz;
        tl_a_source_i  = src;
        tl_a_address_i = addr;
        tl_a_mask_i    = mask;
        tl_a_data_i    = data;
    endtask

    task automatic idle_a();
        tl_a_valid_i   = 1'b0;
        tl_a_opcode_i  = '0;
        tl_a_size_i    = '0;
        tl_a_source_i  = '0;
        tl_a_address_i = '0;
        tl_a_mask_i    = '0;
        tl_a_data_i    = '0;
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (d_tuple() !== 47'h0) begin errors++; $display("FAIL reset_d got %h exp 0", d_tuple()); end
        checks++; if (m_tuple() !== 53'h0) begin errors++; $display("FAIL reset_mem got %h exp 0", m_tuple()); end
        checks++; if (tl_a_ready_o !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", tl_a_ready_o); end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        tl_d_ready_i = 1'b1;
        @(negedge clk);
        drive_a(3'd0, 2'd2, 8'h11, 32'h40, 4'hF, 32'hDEADBEEF);
        #1;
        checks++; if (m_tuple() !== {1'b1, 1'b1, 15'h10, 32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL putfull_mem got %h exp %h", m_tuple(), {1'b1, 1'b1, 15'h10, 32'hDEADBEEF, 4'hF}); end
        @(negedge clk);
        checks++; if (d_tuple() !== {1'b1, 3'd0, 2'd2, 8'h11, 1'b0, 32'h0}) begin errors++; $display("FAIL putfull_ack got %h exp %h", d_tuple(), {1'b1, 3'd0, 2'd2, 8'h11, 1'b0, 32'h0}); end
        drive_a(3'd4, 2'd2, 8'h22, 32'h40, 4'hF, 32'h0);
        #1;
        checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 15'h10}) begin errors++; $display("FAIL get_mem got %h exp %h", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 15'h10}); end
        @(negedge clk);
        idle_a();
        checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'h22, 1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL get_rsp got %h exp %h", d_tuple(), {1'b1, 3'd1, 2'd2, 8'h22, 1'b0, 32'hDEADBEEF}); end
        @(negedge clk);
        checks++; if (tl_d_valid_o !== 1'b0) begin errors++; $display("FAIL wr_rd_drain got %b exp 0", tl_d_valid_o); end
    endtask

    task automatic test_partial();
        @(negedge clk);
        drive_a(3'd1, 2'd0, 8'h33, 32'h41, 4'h2, 32'h0000AB00);
        #1;
        checks++; if (m_tuple() !== {1'b1, 1'b1, 15'h10, 32'h0000AB00, 4'h2}) begin errors++; $display("FAIL partial_mem got %h exp %h", m_tuple(), {1'b1, 1'b1, 15'h10, 32'h0000AB00, 4'h2}); end
        @(negedge clk);
        checks++; if (d_tuple() !== {1'b1, 3'd0, 2'd0, 8'h33, 1'b0, 32'h0}) begin errors++; $display("FAIL partial_ack got %h exp %h", d_tuple(), {1'b1, 3'd0, 2'd0, 8'h33, 1'b0, 32'h0}); end
        drive_a(3'd4, 2'd2, 8'h34, 32'h40, 4'hF, 32'h0);
        @(negedge clk);
        idle_a();
        checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'h34, 1'b0, 32'hDEADABEF}) begin errors++; $display("FAIL partial_rd got %h exp %h", d_tuple(), {1'b1, 3'd1, 2'd2, 8'h34, 1'b0, 32'hDEADABEF}); end
        @(negedge clk);
    endtask

    task automatic test_rom();
        @(negedge clk);
        drive_a(3'd0, 2'd2, 8'h41, 32'h40, 4'hF, 32'hDEADBEEF);
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rom_put_req got %b exp 0", mem_req_o); end
        @(negedge clk);
        checks++; if (d_tuple() !== {1'b1, 3'd0, 2'd2, 8'h41, 1'b1, 32'h0}) begin errors++; $display("FAIL rom_put_ack got %h exp %h", d_tuple(), {1'b1, 3'd0, 2'd2, 8'h41, 1'b1, 32'h0}); end
        drive_a(3'd4, 2'd2, 8'h42, 32'h40, 4'hF, 32'h0);
        #1;
        checks++; if ({mem_req_o, mem_we_o} !== 2'b10) begin errors++; $display("FAIL rom_get_mem got %b exp 10", {mem_req_o, mem_we_o}); end
        @(negedge clk);
        idle_a();
        checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'h42, 1'b0, 32'hA5000010}) begin errors++; $display("FAIL rom_get_rsp got %h exp %h", d_tuple(), {1'b1, 3'd1, 2'd2, 8'h42, 1'b0, 32'hA5000010}); end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [2:0]  ops   [4] = '{3'd4, 3'd4, 3'd2, 3'd0};
        logic [31:0] addrs [4] = '{32'h42, 32'h0002_0000, 32'h0, 32'h44};
        logic [3:0]  masks [4] = '{4'hF, 4'hF, 4'hF, 4'h7};
        logic [2:0]  rops  [4] = '{3'd1, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (d_tuple() !== {1'b1, rops[i-1], 2'd2, 8'h50 + 8'(i-1), 1'b1, 32'h0}) begin errors++; $display("FAIL err_rsp%0d got %h exp %h", i-1, d_tuple(), {1'b1, rops[i-1], 2'd2, 8'h50 + 8'(i-1), 1'b1, 32'h0}); end
            end
            if (i < 4) begin
                drive_a(ops[i], 2'd2, 8'h50 + 8'(i), addrs[i], masks[i], 32'h12345678);
                #1;
                checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL err_req%0d got %b exp 0", i, mem_req_o); end
            end else begin
                idle_a();
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        tl_d_ready_i = 1'b0;
        drive_a(3'd4, 2'd2, 8'h01, 32'h50, 4'hF, 32'h0);
        #1;
        checks++; if (tl_a_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", tl_a_ready_o); end
        @(negedge clk);
        checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'h01, 1'b0, 32'hA5000014}) begin errors++; $display("FAIL bp_head_a got %h exp %h", d_tuple(), {1'b1, 3'd1, 2'd2, 8'h01, 1'b0, 32'hA5000014}); end
        drive_a(3'd4, 2'd2, 8'h02, 32'h54, 4'hF, 32'h0);
        #1;
        checks++; if (tl_a_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %b exp 1", tl_a_ready_o); end
        @(negedge clk);
        drive_a(3'd4, 2'd2, 8'h03, 32'h58, 4'hF, 32'h0);
        #1;
        checks++; if ({tl_a_ready_o, mem_req_o} !== 2'b00) begin errors++; $display("FAIL bp_full got %b exp 00", {tl_a_ready_o, mem_req_o}); end
        checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'h01, 1'b0, 32'hA5000014}) begin errors++; $display("FAIL bp_head_b got %h exp %h", d_tuple(), {1'b1, 3'd1, 2'd2, 8'h01, 1'b0, 32'hA5000014}); end
        @(negedge clk);
        checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'h01, 1'b0, 32'hA5000014}) begin errors++; $display("FAIL bp_head_c got %h exp %h", d_tuple(), {1'b1, 3'd1, 2'd2, 8'h01, 1'b0, 32'hA5000014}); end
        checks++; if (tl_a_ready_o !== 1'b0) begin errors++; $display("FAIL bp_still_full got %b exp 0", tl_a_ready_o); end
        tl_d_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (tl_a_ready_o !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b exp 1", tl_a_ready_o); end
        checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'h02, 1'b0, 32'hA5000015}) begin errors++; $display("FAIL bp_rsp2 got %h exp %h", d_tuple(), {1'b1, 3'd1, 2'd2, 8'h02, 1'b0, 32'hA5000015}); end
        @(negedge clk);
        idle_a();
        checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'h03, 1'b0, 32'hA5000016}) begin errors++; $display("FAIL bp_rsp3 got %h exp %h", d_tuple(), {1'b1, 3'd1, 2'd2, 8'h03, 1'b0, 32'hA5000016}); end
        @(negedge clk);
        checks++; if (tl_d_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", tl_d_valid_o); end
    endtask

    task automatic test_back_to_back();
        int rsp_seen = 0;
        tl_d_ready_i = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (tl_d_valid_o === 1'b1) rsp_seen++;
                checks++; if (d_tuple() !== {1'b1, 3'd1, 2'd2, 8'(k-1), 1'b0, 32'hA5000020 + 32'(k-1)}) begin errors++; $display("FAIL stream_rsp%0d got %h exp %h", k-1, d_tuple(), {1'b1, 3'd1, 2'd2, 8'(k-1), 1'b0, 32'hA5000020 + 32'(k-1)}); end
            end
            if (k < 16) begin
                drive_a(3'd4, 2'd2, 8'(k), 32'h80 + 32'(4*k), 4'hF, 32'h0);
                #1;
                checks++; if (tl_a_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b exp 1", k, tl_a_ready_o); end
            end else begin
                idle_a();
            end
        end
        @(negedge clk);
        checks++; if (tl_d_valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", tl_d_valid_o); end
        checks++; if (rsp_seen !== 16) begin errors++; $display("FAIL stream_count got %0d exp 16", rsp_seen); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        tl_d_ready_i = 1'b0;
        drive_a(3'd4, 2'd2, 8'h77, 32'h60, 4'hF, 32'h0);
        @(negedge clk);
        idle_a();
        checks++; if (tl_d_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", tl_d_valid_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if ({tl_a_ready_o, d_tuple()} !== {1'b1, 47'h0}) begin errors++; $display("FAIL mid_async got %h exp %h", {tl_a_ready_o, d_tuple()}, {1'b1, 47'h0}); end
        @(negedge clk);
        rst_ni = 1'b1;
        tl_d_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (tl_d_valid_o !== 1'b0) begin errors++; $display("FAIL mid_after got %b exp 0", tl_d_valid_o); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        test_reset();
`ifdef TL_MEM_RO_EN
        test_rom();
`else
        test_write_read();
        test_partial();
`endif
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
